// File: rtl/dmem_access_unit_pkg.sv
// dmem_access_unit_pkg: access-size and FSM encodings plus lane helpers for the data-memory access unit.
// Revision 1.0
`default_nettype none

package dmem_access_unit_pkg;

  localparam int DWORD_BYTES = 8;
  localparam int DWORD_W     = 64;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_DOUBLE = 2'b11
  } access_size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MERGE = 3'd3,
    ST_WRITE = 3'd4,
    ST_RESP  = 3'd5
  } dmem_state_e;

  // Byte-enable pattern of an access before it is shifted to its lane.
  function automatic logic [DWORD_BYTES-1:0] size_byte_mask(input access_size_e size);
    case (size)
      SIZE_BYTE: return 8'h01;
      SIZE_HALF: return 8'h03;
      SIZE_WORD: return 8'h0F;
      default:   return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] lane, input access_size_e size);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lane[0];
      SIZE_WORD: return |lane[1:0];
      default:   return |lane;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_access_unit_splice.sv
// byte_lane_splice: extracts/extends a load from a doubleword and merges store lanes into one.
// Revision 1.0
`default_nettype none

module byte_lane_splice
  import dmem_access_unit_pkg::*;
(
  input  logic [DWORD_W-1:0] dword,
  input  logic [DWORD_W-1:0] wdata,
  input  logic [2:0]         lane,
  input  access_size_e       size,
  input  logic               is_unsigned,
  output logic [DWORD_W-1:0] load_data,
  output logic [DWORD_W-1:0] merged
);

  logic [DWORD_W-1:0]     shifted;
  logic [DWORD_W-1:0]     wshift;
  logic [DWORD_BYTES-1:0] byte_en;
  logic                   sext;

  assign shifted = dword >> {lane, 3'b000};
  assign wshift  = wdata << {lane, 3'b000};
  assign byte_en = size_byte_mask(size) << lane;
  assign sext    = ~is_unsigned;

  genvar i;
  generate
    for (i = 0; i < DWORD_BYTES; i++) begin : g_lane
      assign merged[8*i +: 8] = byte_en[i] ? wshift[8*i +: 8] : dword[8*i +: 8];
    end
  endgenerate

  always_comb begin
    load_data = shifted;
    case (size)
      SIZE_BYTE: load_data = {{56{sext & shifted[7]}},  shifted[7:0]};
      SIZE_HALF: load_data = {{48{sext & shifted[15]}}, shifted[15:0]};
      SIZE_WORD: load_data = {{32{sext & shifted[31]}}, shifted[31:0]};
      default:   load_data = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: sequences loads, doubleword stores and read-modify-write partial stores to a 64-bit memory.
// Revision 1.0
`default_nettype none

module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  dmem_state_e       state;
  logic              wr_q;
  logic              uns_q;
  logic              mis_q;
  access_size_e      size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       data_q;

  access_size_e      req_size_e;
  logic              accept;
  logic              req_mis;
  logic [63:0]       load_data;
  logic [63:0]       merged_data;

  assign req_size_e = access_size_e'(req_size);
  assign accept     = req_valid & (state == ST_IDLE);
  assign req_mis    = is_misaligned(req_addr[2:0], req_size_e);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wr_q    <= req_write;
            uns_q   <= req_unsigned;
            mis_q   <= req_mis;
            size_q  <= req_size_e;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            data_q  <= '0;
            // Only full-doubleword stores can skip the read; partial stores need the old data.
            if (req_mis)
              state <= ST_RESP;
            else if (req_write && (req_size_e == SIZE_DOUBLE))
              state <= ST_WRITE;
            else
              state <= ST_READ;
          end
        end
        ST_READ: state <= ST_WAIT;
        ST_WAIT: begin
          data_q <= mem_rdata;
          state  <= wr_q ? ST_MERGE : ST_RESP;
        end
        ST_MERGE: state <= ST_RESP;
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  byte_lane_splice u_splice (
    .dword       (data_q),
    .wdata       (wdata_q),
    .lane        (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged      (merged_data)
  );

  always_comb begin
    req_ready       = (state == ST_IDLE);
    resp_valid      = (state == ST_RESP);
    resp_misaligned = (state == ST_RESP) & mis_q;
    resp_rdata      = '0;
    mem_rd          = (state == ST_READ);
    mem_wr          = (state == ST_WRITE) || (state == ST_MERGE);
    mem_addr        = '0;
    mem_wdata       = '0;
    if ((state == ST_RESP) && !wr_q && !mis_q)
      resp_rdata = load_data;
    if ((state == ST_READ) || (state == ST_WAIT) || (state == ST_WRITE) || (state == ST_MERGE))
      mem_addr = {addr_q[ADDR_W-1:3], 3'b000};
    if (state == ST_WRITE)
      mem_wdata = wdata_q;
    else if (state == ST_MERGE)
      mem_wdata = merged_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed and randomized checks of dmem_access_unit against a byte-level reference model.
// Revision 1.0
`default_nettype none

module tb_dmem_access_unit;

  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [63:0]       req_wdata = '0;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_misaligned;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  logic [63:0] mem     [0:63];
  logic [63:0] ref_mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [63:0] pre_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: read data appears the cycle after the mem_rd cycle.
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_wr) mem[mem_addr[8:3]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[8:3]];
  end

  function automatic logic [63:0] model_load(input logic [63:0] dw, input int lane, input int nb, input bit sext);
    logic [63:0] v = '0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = dw[8*(lane+k) +: 8];
    if (sext && nb < 8 && v[8*nb-1])
      for (int k = nb; k < 8; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] model_store(input logic [63:0] dw, input logic [63:0] wd, input int lane, input int nb);
    logic [63:0] v = dw;
    for (int k = 0; k < nb; k++) v[8*(lane+k) +: 8] = wd[8*k +: 8];
    return v;
  endfunction

  task automatic preload(input int idx, input logic [63:0] val);
    pre_en = 1'b1; pre_idx = 6'(idx); pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Drives one request from a negedge and returns what came back; leaves the bench at a negedge with the unit idle.
  task automatic issue(input bit w, input logic [1:0] sz, input bit u, input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output bit mis, output int lat, output int n_rd, output int n_wr,
                       output int n_bad);
    int guard = 0;
    rd = '0; mis = 1'b0; lat = 0; n_rd = 0; n_wr = 0; n_bad = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    lat = 1;
    while (!resp_valid && lat < 20) begin
      if (mem_rd) n_rd++;
      if (mem_wr) n_wr++;
      if ((mem_rd && mem_wr) || ((mem_rd || mem_wr) && mem_addr !== {a[63:3], 3'b000})) n_bad++;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL issue_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, lat);
    end
    rd = resp_rdata;
    mis = resp_misaligned;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_misaligned, mem_rd, mem_wr} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: {ready,rvalid,mis,rd,wr}=%b, required 10000",
               {req_ready, resp_valid, resp_misaligned, mem_rd, mem_wr});
    end
    checks++;
    if ({resp_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required all 0", resp_rdata, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) preload(i, {$urandom, $urandom});
  endtask

  task automatic test_directed;
    logic [63:0] rd; bit mis; int lat, nr, nw, nb;
    preload(2, 64'h1122334455667788);
    preload(3, 64'h0000000000000080);
    preload(4, 64'hAAAAAAAAAAAAAAAA);
    issue(1'b0, 2'b11, 1'b0, 64'h10, '0, rd, mis, lat, nr, nw, nb);
    checks++;
    if (rd !== 64'h1122334455667788 || lat != 3) begin
      errors++; $display("FAIL ld_double: rdata=%h lat=%0d, required 1122334455667788 lat=3", rd, lat);
    end
    issue(1'b0, 2'b00, 1'b0, 64'h17, '0, rd, mis, lat, nr, nw, nb);
    checks++;
    if (rd !== 64'h11) begin errors++; $display("FAIL lb_pos: rdata=%h, required 11", rd); end
    issue(1'b0, 2'b00, 1'b0, 64'h18, '0, rd, mis, lat, nr, nw, nb);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_neg: rdata=%h, required ffffffffffffff80", rd); end
    issue(1'b0, 2'b00, 1'b1, 64'h18, '0, rd, mis, lat, nr, nw, nb);
    checks++;
    if (rd !== 64'h80) begin errors++; $display("FAIL lbu: rdata=%h, required 80", rd); end
    issue(1'b1, 2'b01, 1'b0, 64'h22, 64'h1234, rd, mis, lat, nr, nw, nb);
    ref_mem[4] = 64'hAAAAAAAA1234AAAA;
    checks++;
    if (mem[4] !== 64'hAAAAAAAA1234AAAA || lat != 4 || rd !== '0 || nw != 1) begin
      errors++;
      $display("FAIL sh_partial: mem=%h lat=%0d rdata=%h wr=%0d, required aaaaaaaa1234aaaa lat=4 rdata=0 wr=1",
               mem[4], lat, rd, nw);
    end
  endtask

  task automatic test_misaligned;
    logic [63:0] rd; bit mis; int lat, nr, nw, nb;
    issue(1'b0, 2'b10, 1'b0, 64'h0A, '0, rd, mis, lat, nr, nw, nb);
    checks++;
    if (mis !== 1'b1 || lat != 1 || nr != 0 || nw != 0 || rd !== '0) begin
      errors++;
      $display("FAIL misaligned_lw: mis=%b lat=%0d rd=%0d wr=%0d rdata=%h, required 1 1 0 0 0", mis, lat, nr, nw, rd);
    end
  endtask

  task automatic test_reset_midop;
    int bad = 0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 64'h31; req_wdata = 64'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_rd !== 1'b1) begin errors++; $display("FAIL midop_read: mem_rd=%b, required 1", mem_rd); end
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_wr !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_abort: ready=%b wr=%b rvalid=%b, required 1 0 0", req_ready, mem_wr, resp_valid);
    end
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_wins: req_ready=%b, required 1", req_ready); end
    for (int i = 0; i < 5; i++) begin
      if (mem_wr || mem_rd || resp_valid) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || mem[6] !== ref_mem[6]) begin
      errors++; $display("FAIL midop_quiet: stray_cycles=%0d mem=%h, required 0 %h", bad, mem[6], ref_mem[6]);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] wd = {$urandom, $urandom};
    logic [63:0] rd = '0;
    int c = 1, first_resp = -1, acc2 = -1, second_resp = -1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_unsigned = 1'b0; req_addr = 64'h40; req_wdata = wd;
    @(negedge clk);
    req_write = 1'b0; req_wdata = '0;
    while (c < 30 && second_resp < 0) begin
      if (resp_valid && first_resp < 0) first_resp = c;
      else if (resp_valid && acc2 >= 0) begin second_resp = c; rd = resp_rdata; end
      if (req_ready && acc2 < 0) acc2 = c;
      @(negedge clk);
      if (acc2 >= 0) req_valid = 1'b0;
      c++;
    end
    ref_mem[8] = wd;
    checks++;
    if (first_resp != 2 || acc2 != 3 || second_resp != 6) begin
      errors++;
      $display("FAIL b2b_timing: resp1=%0d accept2=%0d resp2=%0d, required 2 3 6", first_resp, acc2, second_resp);
    end
    checks++;
    if (rd !== wd) begin errors++; $display("FAIL b2b_data: rdata=%h, required %h", rd, wd); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    logic [63:0] rd, a, wd, exp_rd; bit mis, w, u, exp_mis; int lat, nr, nw, nb, sz, nbytes, lane, idx;
    int exp_lat, exp_nr, exp_nw;
    for (int t = 0; t < 60; t++) begin
      sz = $urandom_range(0, 3); nbytes = 1 << sz;
      a = 64'($urandom_range(0, 511));
      if ($urandom_range(0, 4) != 0) a = a & ~64'(nbytes - 1);
      w = 1'($urandom); u = 1'($urandom); wd = {$urandom, $urandom};
      idx = int'(a[8:3]); lane = int'(a[2:0]);
      exp_mis = (lane % nbytes) != 0;
      exp_rd  = (exp_mis || w) ? 64'h0 : model_load(ref_mem[idx], lane, nbytes, !u);
      exp_lat = exp_mis ? 1 : (!w ? 3 : (nbytes == 8 ? 2 : 4));
      exp_nr  = (!exp_mis && (!w || nbytes < 8)) ? 1 : 0;
      exp_nw  = (!exp_mis && w) ? 1 : 0;
      issue(w, 2'(sz), u, a, wd, rd, mis, lat, nr, nw, nb);
      if (exp_nw == 1) ref_mem[idx] = model_store(ref_mem[idx], wd, lane, nbytes);
      checks++;
      if (rd !== exp_rd || mis !== exp_mis || lat != exp_lat || nr != exp_nr || nw != exp_nw || nb != 0) begin
        errors++;
        $display("FAIL random_%0d: w=%b sz=%0d a=%h rdata=%h mis=%b lat=%0d rd=%0d wr=%0d bad=%0d, required %h %b %0d %0d %0d 0",
                 t, w, sz, a, rd, mis, lat, nr, nw, nb, exp_rd, exp_mis, exp_lat, exp_nr, exp_nw);
      end
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin
        errors++; $display("FAIL mem_final_%0d: mem=%h, required %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_misaligned();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
